alu_sequencer: RTL and testbench

Operand/operation sequencer for the switch-driven ALU. It synchronises and debounces the raw "do" push-button and walks a four-state cycle: load A, load B plus operation select, execute, show. It holds the operand, select and result registers that feed the `operations` ALU and the `seven_seg` display. It sits in `top` between the board switches and buttons and those two blocks, so A and B no longer need to be driven directly from the switches.

---
 rtl/alu_sequencer_if.sv | 26 ++
 rtl/alu_sequencer.sv | 132 +++++++++++++
 tb/tb_alu_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - button/switch inputs and operand/result outputs of the ALU sequencer
interface alu_sequencer_if;
    logic       btn_do;
    logic [7:0] sw_data;
    logic [3:0] sw_sel;
    logic [7:0] alu_y;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [3:0] sel_reg;
    logic [7:0] y_reg;
    logic       y_valid;
    logic [1:0] state;
    logic       busy;
    logic       press;
    logic [7:0] op_count;

    modport slave (
        input  btn_do, sw_data, sw_sel, alu_y,
        output a_reg, b_reg, sel_reg, y_reg, y_valid, state, busy, press, op_count
    );

    modport master (
        output btn_do, sw_data, sw_sel, alu_y,
        input  a_reg, b_reg, sel_reg, y_reg, y_valid, state, busy, press, op_count
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - debounced push-button sequencer: load A, load B/select, execute, show
module alu_sequencer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ALU_LAT         = 1
) (
    input  logic           clk,
    input  logic           reset,
    alu_sequencer_if.slave bus
);
    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int EW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [EW-1:0] EXEC_INIT = EW'(ALU_LAT - 1);

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'b00,
        ST_LOAD_B = 2'b01,
        ST_EXEC   = 2'b10,
        ST_SHOW   = 2'b11
    } state_t;

    logic          r_s1;
    logic          r_s2;
    logic          r_stable;
    logic          r_stable_d;
    logic [CW-1:0] r_db_cnt;
    state_t        r_state;
    logic [EW-1:0] r_exec_cnt;
    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic [3:0]    r_sel;
    logic [7:0]    r_y;
    logic          r_y_valid;
    logic [7:0]    r_op_count;

    state_t        w_next_state;
    logic          w_press;
    logic          w_ld_a;
    logic          w_ld_b;
    logic          w_capture;

    assign w_press = r_stable & ~r_stable_d;

    // Synchroniser and debouncer; the counter only runs while s2 disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_s1       <= bus.btn_do;
            r_s2       <= r_s1;
            r_stable_d <= r_stable;
            if (r_s2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_stable <= r_s2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ld_a       = 1'b0;
        w_ld_b       = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_LOAD_A: if (w_press) begin
                w_ld_a       = 1'b1;
                w_next_state = ST_LOAD_B;
            end
            ST_LOAD_B: if (w_press) begin
                w_ld_b       = 1'b1;
                w_next_state = ST_EXEC;
            end
            ST_EXEC: if (r_exec_cnt == '0) begin
                w_capture    = 1'b1;
                w_next_state = ST_SHOW;
            end
            ST_SHOW: if (w_press) begin
                w_next_state = ST_LOAD_A;
            end
            default: w_next_state = ST_LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_LOAD_A;
            r_exec_cnt <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_sel      <= '0;
            r_y        <= '0;
            r_y_valid  <= 1'b0;
            r_op_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ld_a) begin
                r_a       <= bus.sw_data;
                r_y_valid <= 1'b0;
            end
            if (w_ld_b) begin
                r_b        <= bus.sw_data;
                r_sel      <= bus.sw_sel;
                r_exec_cnt <= EXEC_INIT;
            end else if (r_state == ST_EXEC && r_exec_cnt != '0) begin
                r_exec_cnt <= r_exec_cnt - 1'b1;
            end
            if (w_capture) begin
                r_y        <= bus.alu_y;
                r_y_valid  <= 1'b1;
                r_op_count <= r_op_count + 8'd1;
            end
        end
    end

    assign bus.a_reg    = r_a;
    assign bus.b_reg    = r_b;
    assign bus.sel_reg  = r_sel;
    assign bus.y_reg    = r_y;
    assign bus.y_valid  = r_y_valid;
    assign bus.state    = r_state;
    assign bus.busy     = (r_state == ST_EXEC);
    assign bus.press    = w_press;
    assign bus.op_count = r_op_count;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed bench for alu_sequencer, short and long EXEC instances
module tb_alu_sequencer;
    logic       clk = 1'b0;
    logic       rstn;
    logic       btn;
    logic [7:0] sw_data;
    logic [3:0] sw_sel;
    int         vectors = 0;
    int         errs = 0;
    int         cyc = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        case (s)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    alu_sequencer_if bus1 ();
    alu_sequencer_if bus2 ();

    assign bus1.btn_do  = btn;
    assign bus1.sw_data = sw_data;
    assign bus1.sw_sel  = sw_sel;
    assign bus1.alu_y   = alu_model(bus1.a_reg, bus1.b_reg, bus1.sel_reg);
    assign bus2.btn_do  = btn;
    assign bus2.sw_data = sw_data;
    assign bus2.sw_sel  = sw_sel;
    assign bus2.alu_y   = alu_model(bus2.a_reg, bus2.b_reg, bus2.sel_reg);

    alu_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_LAT(2))  u_dut1 (.clk(clk), .reset(rstn), .bus(bus1));
    alu_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_LAT(16)) u_dut2 (.clk(clk), .reset(rstn), .bus(bus2));

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag, input int which);
        if (which == 1)
            check(tag, {bus1.a_reg, bus1.b_reg, bus1.sel_reg, bus1.y_reg, bus1.y_valid,
                        bus1.state, bus1.busy, bus1.press, bus1.op_count}, 32'h0);
        else
            check(tag, {bus2.a_reg, bus2.b_reg, bus2.sel_reg, bus2.y_reg, bus2.y_valid,
                        bus2.state, bus2.busy, bus2.press, bus2.op_count}, 32'h0);
    endtask

    // Raise the button, wait for the debounced pulse, then let the FSM act on it.
    task automatic press_and_act();
        int n;
        n = 0;
        btn = 1'b1;
        while (bus1.press !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("press_seen", {31'd0, bus1.press}, 32'd1);
        step();
        btn = 1'b0;
    endtask

    task automatic wait_release();
        repeat (7) step();
    endtask

    initial begin
        int presses;
        int e0;
        int n;
        logic [7:0] ea;
        logic [7:0] eb;
        logic [3:0] es;

        rstn    = 1'b0;
        btn     = 1'b1;
        sw_data = 8'h00;
        sw_sel  = 4'h0;
        repeat (3) step();
        check_zero("reset_outputs_dut1", 1);
        check_zero("reset_outputs_dut2", 2);

        sw_data = 8'h12;
        rstn    = 1'b1;
        repeat (5) step();
        check("reset_release_no_early_press", {31'd0, bus1.press}, 32'd0);
        step();
        check("reset_release_press_at_6", {31'd0, bus1.press}, 32'd1);
        step();
        check("press_one_cycle", {31'd0, bus1.press}, 32'd0);
        check("load_a_state", {30'd0, bus1.state}, 32'd1);
        check("load_a_value", {24'd0, bus1.a_reg}, 32'h12);
        check("load_a_yvalid", {31'd0, bus1.y_valid}, 32'd0);
        btn = 1'b0;
        wait_release();

        sw_data = 8'h34;
        sw_sel  = 4'h1;
        presses = 0;
        btn = 1'b1; step(); presses += int'(bus1.press);
        btn = 1'b0; step(); presses += int'(bus1.press);
        btn = 1'b1; step(); presses += int'(bus1.press);
        btn = 1'b0; step(); presses += int'(bus1.press);
        btn = 1'b1;
        repeat (5) begin
            step();
            presses += int'(bus1.press);
        end
        step();
        check("bounce_press_at_6", {31'd0, bus1.press}, 32'd1);
        presses += int'(bus1.press);
        check("bounce_single_press", presses, 32'd1);
        step();
        e0 = cyc;
        btn = 1'b0;
        sw_data = 8'hA5;
        sw_sel  = 4'hE;
        check("exec_entry_state", {30'd0, bus1.state}, 32'd2);
        check("exec_entry_busy", {31'd0, bus1.busy}, 32'd1);
        check("load_b_value", {24'd0, bus1.b_reg}, 32'h34);
        check("load_b_sel", {28'd0, bus1.sel_reg}, 32'd1);
        check("a_held", {24'd0, bus1.a_reg}, 32'h12);
        step();
        check("exec_second_cycle_busy", {31'd0, bus1.busy}, 32'd1);
        step();
        check("show_state", {30'd0, bus1.state}, 32'd3);
        check("show_busy", {31'd0, bus1.busy}, 32'd0);
        check("show_y", {24'd0, bus1.y_reg}, 32'h46);
        check("show_yvalid", {31'd0, bus1.y_valid}, 32'd1);
        check("show_opcount", {24'd0, bus1.op_count}, 32'd1);
        check("long_exec_still_busy", {30'd0, bus2.state}, 32'd2);

        repeat (5) step();
        btn = 1'b1;
        n = 0;
        while (bus2.press !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("exec_press_seen", {31'd0, bus2.press}, 32'd1);
        check("exec_press_state", {30'd0, bus2.state}, 32'd2);
        step();
        btn = 1'b0;
        check("exec_press_ignored", {30'd0, bus2.state}, 32'd2);
        check("show_press_to_load_a", {30'd0, bus1.state}, 32'd0);
        check("yvalid_kept_in_load_a", {31'd0, bus1.y_valid}, 32'd1);
        n = 0;
        while (bus2.state !== 2'd3 && n < 30) begin
            step();
            n++;
        end
        check("long_exec_occupancy", cyc - e0, 32'd16);
        check("long_exec_y", {24'd0, bus2.y_reg}, 32'h46);
        check("long_exec_yvalid", {31'd0, bus2.y_valid}, 32'd1);
        check("long_exec_opcount", {24'd0, bus2.op_count}, 32'd1);
        wait_release();
        check("long_exec_no_extra_transition", {30'd0, bus2.state}, 32'd3);

        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        sw_data = 8'hFF;
        press_and_act();
        check("midop_load_b_state", {30'd0, bus1.state}, 32'd1);
        check("midop_a_ff", {24'd0, bus1.a_reg}, 32'hFF);
        check("midop_a_ff_dut2", {24'd0, bus2.a_reg}, 32'hFF);
        rstn = 1'b0;
        step();
        check_zero("midop_reset_dut1", 1);
        check_zero("midop_reset_dut2", 2);
        rstn = 1'b1;
        sw_data = 8'h00;
        step();

        for (int i = 0; i < 256; i++) begin
            ea = i[7:0];
            eb = i[7:0] ^ 8'h5A;
            es = i[3:0] & 4'h3;
            sw_data = ea;
            press_and_act();
            sw_data = ~ea;
            wait_release();
            sw_data = eb;
            sw_sel  = es;
            press_and_act();
            sw_data = ~eb;
            sw_sel  = ~es;
            wait_release();
            check("wrap_state", {30'd0, bus1.state}, 32'd3);
            check("wrap_a", {24'd0, bus1.a_reg}, {24'd0, ea});
            check("wrap_b", {24'd0, bus1.b_reg}, {24'd0, eb});
            check("wrap_sel", {28'd0, bus1.sel_reg}, {28'd0, es});
            check("wrap_y", {24'd0, bus1.y_reg}, {24'd0, alu_model(ea, eb, es)});
            check("wrap_opcount", {24'd0, bus1.op_count}, (i + 1) % 256);
            press_and_act();
            wait_release();
        end
        check("wrap_final_opcount", {24'd0, bus1.op_count}, 32'd0);
        check("wrap_final_state", {30'd0, bus1.state}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
